vga_fb_scanout: RTL



---
 rtl/vga_fb_scanout.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
// 1-bpp framebuffer scanout: VGA timing from a pixel clock-enable, Hack-format
// screen words fetched from a 1-cycle-latency RAM, bits replicated by SCALE.
module vga_fb_scanout #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int CLK_DIV   = 4,
    parameter int SCALE     = 2,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       screen_in,
    input  logic [11:0]       fg_color,
    input  logic [11:0]       bg_color,
    output logic [ADDR_W-1:0] screen_addr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WPR     = H_ACTIVE / SCALE / 16;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int SH      = $clog2(SCALE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0]  HS_BEG   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]  HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VC_W-1:0]  VS_BEG   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]  VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON  = 1'(SYNC_POL);

    logic [DIV_W-1:0]  div;
    logic              pix_ce;
    logic [HC_W-1:0]   hc;
    logic [VC_W-1:0]   vc;
    logic              h_wrap;
    logic              frame_wrap;
    logic              act0;
    logic              hs_on0;
    logic              vs_on0;
    logic [HC_W-1:0]   hc_px;
    logic [VC_W-1:0]   vc_px;
    logic [ADDR_W-1:0] addr0;
    logic              act1;
    logic              hs1;
    logic              vs1;
    logic [3:0]        bit1;
    logic [11:0]       fg_lat;
    logic [11:0]       bg_lat;
    logic [11:0]       rgb;

    assign pix_ce     = (div == DIV_LAST);
    assign h_wrap     = (hc == H_LAST);
    assign frame_wrap = h_wrap && (vc == V_LAST);
    assign act0       = (hc < H_ACT) && (vc < V_ACT);
    assign hs_on0     = (hc >= HS_BEG) && (hc <= HS_END);
    assign vs_on0     = (vc >= VS_BEG) && (vc <= VS_END);
    assign hc_px      = hc >> SH;
    assign vc_px      = vc >> SH;
    assign addr0      = ADDR_W'(BASE_ADDR) + ADDR_W'(vc_px) * ADDR_W'(WPR) + ADDR_W'(hc_px >> 4);

    // Gated by reset so the pulse can never appear while outputs are being cleared.
    assign frame_start = pix_ce && frame_wrap && !reset;

    always_ff @(posedge clk) begin
        if (reset || pix_ce) div <= '0;
        else                 div <= div + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Stage 1: decode position and issue the word read; the address is held
    // through blanking so memory sees no reads outside the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            act1        <= 1'b0;
            hs1         <= ~SYNC_ON;
            vs1         <= ~SYNC_ON;
            bit1        <= 4'd0;
            screen_addr <= ADDR_W'(BASE_ADDR);
        end else if (pix_ce) begin
            act1 <= act0;
            hs1  <= hs_on0 ? SYNC_ON : ~SYNC_ON;
            vs1  <= vs_on0 ? SYNC_ON : ~SYNC_ON;
            bit1 <= 4'(hc_px);
            if (act0) screen_addr <= addr0;
        end
    end

    // Stage 2: read data has settled (CLK_DIV >= 3), syncs delayed to match.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hs <= ~SYNC_ON;
            vga_vs <= ~SYNC_ON;
            rgb    <= 12'h000;
        end else if (pix_ce) begin
            vga_hs <= hs1;
            vga_vs <= vs1;
            rgb    <= act1 ? (screen_in[bit1] ? fg_lat : bg_lat) : 12'h000;
        end
    end

    // Colours change only at frame boundaries to avoid tearing mid-frame.
    always_ff @(posedge clk) begin
        if (reset || (pix_ce && frame_wrap)) begin
            fg_lat <= fg_color;
            bg_lat <= bg_color;
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];
endmodule
